// File: rtl/grey_pkg.sv
// Shared types and helpers for the grey column feeder.
//   grey_t    8-bit grey sample
//   column_t  24-bit vertical column {top, mid, bot}
//   rgb_t     24-bit pixel {R, G, B}
//   state_t   feeder sequencing states
package grey_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned RGB_W = 3 * PIX_W;
  localparam int unsigned COL_W = 3 * PIX_W;

  // Default luma weights in Q0.8; they sum to 256.
  localparam int unsigned DEF_CW_R = 77;
  localparam int unsigned DEF_CW_G = 150;
  localparam int unsigned DEF_CW_B = 29;

  typedef logic [PIX_W-1:0] grey_t;
  typedef logic [COL_W-1:0] column_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  function automatic rgb_t unpack_rgb(input logic [RGB_W-1:0] d);
    return rgb_t'(d);
  endfunction

  function automatic logic [RGB_W-1:0] pack_rgb(input rgb_t p);
    return RGB_W'(p);
  endfunction

  function automatic column_t pack_column(input grey_t top, input grey_t mid, input grey_t bot);
    return {top, mid, bot};
  endfunction

  function automatic void unpack_column(input column_t c, output grey_t top,
                                        output grey_t mid, output grey_t bot);
    top = c[3*PIX_W-1:2*PIX_W];
    mid = c[2*PIX_W-1:PIX_W];
    bot = c[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/grey_column_feeder_rgb_to_grey.sv
// Combinational RGB to grey conversion: g = (CW_R*R + CW_G*G + CW_B*B) >> 8, truncated.
//   rgb   in  24  {R, G, B}
//   grey  out 8   grey value
module rgb_to_grey
  import grey_pkg::*;
#(
  parameter int unsigned CW_R = DEF_CW_R,
  parameter int unsigned CW_G = DEF_CW_G,
  parameter int unsigned CW_B = DEF_CW_B
) (
  input  logic [RGB_W-1:0] rgb,
  output grey_t            grey
);

  localparam int unsigned SUM_W = 16;
  localparam logic [SUM_W-1:0] WR = SUM_W'(CW_R);
  localparam logic [SUM_W-1:0] WG = SUM_W'(CW_G);
  localparam logic [SUM_W-1:0] WB = SUM_W'(CW_B);

  rgb_t             px;
  logic [SUM_W-1:0] sum;

  assign px = unpack_rgb(rgb);

  // Weights sum to 256, so the worst case 256*255 fits 16 bits unsigned.
  assign sum  = WR * SUM_W'(px.r) + WG * SUM_W'(px.g) + WB * SUM_W'(px.b);
  assign grey = PIX_W'(sum >> 8);

endmodule

// File: rtl/grey_column_feeder.sv
// Converts raster RGB pixels to grey and emits one 3-row grey column per pixel
// position, using two line buffers and zero padding above row 0 / below row H-1.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rgb_vld/data/busy       upstream pixel handshake (busy driven here)
//   o_grey_vld/data/busy      downstream column handshake (busy driven downstream)
module grey_column_feeder
  import grey_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256,
  parameter int unsigned CW_R       = DEF_CW_R,
  parameter int unsigned CW_G       = DEF_CW_G,
  parameter int unsigned CW_B       = DEF_CW_B
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rgb_vld,
  input  logic [RGB_W-1:0] i_rgb_data,
  output logic             i_rgb_busy,
  output logic             o_grey_vld,
  output logic [COL_W-1:0] o_grey_data,
  input  logic             o_grey_busy
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [RW-1:0]   r_q, r_d;
  logic            busy_c;
  logic            wr_en_c;
  logic            load_c;
  column_t         col_c;
  logic            x_last, r_last;
  grey_t           g;
  grey_t           lb0_rd, lb1_rd;

  // lb0 holds row r-1, lb1 holds row r-2; never cleared, validity follows r.
  grey_t lb0 [IMG_WIDTH];
  grey_t lb1 [IMG_WIDTH];

  rgb_to_grey #(
    .CW_R(CW_R),
    .CW_G(CW_G),
    .CW_B(CW_B)
  ) u_rgb_to_grey (
    .rgb (i_rgb_data),
    .grey(g)
  );

  assign lb0_rd     = lb0[x_q];
  assign lb1_rd     = lb1[x_q];
  assign x_last     = (x_q == XW'(IMG_WIDTH - 1));
  assign r_last     = (r_q == RW'(IMG_HEIGHT - 1));
  assign i_rgb_busy = busy_c;

  // Next-state, counters, upstream busy and output-register load.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    busy_c  = 1'b0;
    wr_en_c = 1'b0;
    load_c  = 1'b0;
    col_c   = '0;
    case (state_q)
      FILL: begin
        wr_en_c = i_rgb_vld;
        if (wr_en_c) begin
          if (x_last) begin
            x_d     = '0;
            r_d     = RW'(1);
            state_d = STREAM;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      STREAM: begin
        // Accept only when the output register is empty or draining this cycle.
        busy_c  = o_grey_vld & o_grey_busy;
        wr_en_c = i_rgb_vld & ~busy_c;
        load_c  = wr_en_c;
        // At r=1 lb1 still holds stale data from a previous frame: pad with zero.
        col_c   = pack_column((r_q != RW'(1)) ? lb1_rd : '0, lb0_rd, g);
        if (wr_en_c && x_last) begin
          x_d = '0;
          if (r_last) begin
            state_d = FLUSH;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else if (wr_en_c) begin
          x_d = x_q + 1'b1;
        end
      end
      FLUSH: begin
        busy_c = 1'b1;
        load_c = ~o_grey_vld | ~o_grey_busy;
        col_c  = pack_column(lb1_rd, lb0_rd, '0);
        if (load_c) begin
          if (x_last) begin
            x_d     = '0;
            r_d     = '0;
            state_d = FILL;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = FILL;
        x_d     = '0;
        r_d     = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      x_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
    end
  end

  // Line buffer shift; reads above see the pre-write contents.
  always_ff @(posedge i_clk) begin
    if (wr_en_c && !i_rst) begin
      lb1[x_q] <= lb0_rd;
      lb0[x_q] <= g;
    end
  end

  // Single-entry output register; load and drain may coincide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_grey_vld  <= 1'b0;
      o_grey_data <= '0;
    end else if (load_c) begin
      o_grey_vld  <= 1'b1;
      o_grey_data <= col_c;
    end else if (o_grey_vld && !o_grey_busy) begin
      o_grey_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grey_column_feeder.sv
// Bench for grey_column_feeder: directed 4x3 frames from a vector table plus a
// randomised 64x64 frame on a second instance against a reference model.
module tb_grey_column_feeder;

  typedef struct {
    logic [23:0] rgb;
    logic [23:0] col;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        rgb_vld = 1'b0;
  logic [23:0] rgb_data = '0;
  logic        rgb_busy;
  logic        grey_vld;
  logic [23:0] grey_data;
  logic        grey_busy = 1'b0;

  logic        big_vld = 1'b0;
  logic [23:0] big_data = '0;
  logic        big_busy;
  logic        big_ovld;
  logic [23:0] big_odata;
  logic        big_obusy = 1'b0;
  logic        big_run = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int sent = 0;
  int big_cnt = 0;
  int big_bad = 0;
  logic mon_en = 1'b1;
  logic prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  logic [23:0] exp_q[$];
  logic [23:0] big_q[$];
  vec_t tbl[3][12];
  logic [23:0] img[64][64];
  logic [7:0]  gimg[64][64];

  always #5 clk = ~clk;

  grey_column_feeder #(.IMG_WIDTH(4), .IMG_HEIGHT(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rgb_vld(rgb_vld), .i_rgb_data(rgb_data), .i_rgb_busy(rgb_busy),
    .o_grey_vld(grey_vld), .o_grey_data(grey_data), .o_grey_busy(grey_busy)
  );

  grey_column_feeder #(.IMG_WIDTH(64), .IMG_HEIGHT(64)) dut_big (
    .i_clk(clk), .i_rst(rst),
    .i_rgb_vld(big_vld), .i_rgb_data(big_data), .i_rgb_busy(big_busy),
    .o_grey_vld(big_ovld), .o_grey_data(big_odata), .o_grey_busy(big_obusy)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] ref_grey(input logic [23:0] p);
    logic [15:0] s;
    s = 16'd77 * {8'd0, p[23:16]} + 16'd150 * {8'd0, p[15:8]} + 16'd29 * {8'd0, p[7:0]};
    return s[15:8];
  endfunction

  // Small-instance scoreboard and stall-stability checks.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("hold_vld", 32'(grey_vld), 32'd1);
      chk("hold_data", 32'(grey_data), 32'(prev_data));
    end
    if (mon_en && grey_vld === 1'b1 && !grey_busy) begin
      if (exp_q.size() == 0) chk("extra_col", 32'(exp_q.size()), 32'd1);
      else chk("col", 32'(grey_data), 32'(exp_q.pop_front()));
    end
    prev_stall = (grey_vld === 1'b1) && grey_busy && !rst;
    prev_data  = grey_data;
    if (rgb_busy === 1'b1) busy_cnt++;
  end

  // Big-instance scoreboard.
  always @(negedge clk) begin
    if (big_ovld === 1'b1 && !big_obusy) begin
      big_cnt++;
      if (big_q.size() == 0) big_bad++;
      else if (big_q.pop_front() !== big_odata) big_bad++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (big_run) big_obusy = ($urandom_range(3) == 0);
  end

  task automatic send(input logic [23:0] p);
    int n;
    n = 0;
    rgb_vld  = 1'b1;
    rgb_data = p;
    @(negedge clk);
    while (rgb_busy && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("accept_timeout", 32'(rgb_busy), 32'd0);
    @(posedge clk); #1;
    rgb_vld = 1'b0;
    sent++;
  endtask

  task automatic send_big(input logic [23:0] p);
    int n;
    n = 0;
    while ($urandom_range(3) == 0) begin
      big_vld = 1'b0;
      @(posedge clk); #1;
    end
    big_vld  = 1'b1;
    big_data = p;
    @(negedge clk);
    while (big_busy && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) chk("big_accept_timeout", 32'(big_busy), 32'd0);
    @(posedge clk); #1;
    big_vld = 1'b0;
  endtask

  task automatic run_frame(input int f);
    for (int i = 0; i < 12; i++) exp_q.push_back(tbl[f][i].col);
    for (int i = 0; i < 12; i++) send(tbl[f][i].rgb);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [23:0] conv_in[4];
    logic [23:0] conv_col[12];
    int n;
    conv_in  = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h000000};
    conv_col = '{24'h0001FF, 24'h00014C, 24'h000195, 24'h000100,
                 24'h01FF03, 24'h014C03, 24'h019503, 24'h010003,
                 24'hFF0300, 24'h4C0300, 24'h950300, 24'h000300};
    for (int x = 0; x < 4; x++) begin
      tbl[0][x]     = '{24'h010101, conv_col[x]};
      tbl[0][4 + x] = '{conv_in[x], conv_col[4 + x]};
      tbl[0][8 + x] = '{24'h030303, conv_col[8 + x]};
      tbl[1][x]     = '{24'h010101, 24'h000102};
      tbl[1][4 + x] = '{24'h020202, 24'h010203};
      tbl[1][8 + x] = '{24'h030303, 24'h020300};
      tbl[2][x]     = '{24'h040404, 24'h000405};
      tbl[2][4 + x] = '{24'h050505, 24'h040506};
      tbl[2][8 + x] = '{24'h060606, 24'h050600};
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_vld", 32'(grey_vld), 32'd0);
    chk("rst_data", 32'(grey_data), 32'd0);
    chk("rst_rgb_busy", 32'(rgb_busy), 32'd0);

    // Conversion values carried through a frame.
    run_frame(0);
    wait_drain("conv_drain");

    // Plain frame; upstream busy only during the flush.
    busy_cnt = 0;
    run_frame(1);
    wait_drain("frame_drain");
    chk("flush_busy_cycles", 32'(busy_cnt), 32'd4);

    // Downstream backpressure for 5 cycles mid-stream.
    sent = 0;
    fork
      run_frame(1);
      begin
        wait (sent == 6);
        grey_busy = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("bp_rgb_busy", 32'(rgb_busy), 32'd1);
        end
        @(posedge clk); #1;
        grey_busy = 1'b0;
      end
    join
    wait_drain("bp_drain");

    // Reset at row 1, x=2, then a clean frame.
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) send(tbl[1][i].rgb);
    rgb_vld  = 1'b1;
    rgb_data = tbl[1][6].rgb;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rgb_vld = 1'b0;
    chk("midrst_vld", 32'(grey_vld), 32'd0);
    chk("midrst_rgb_busy", 32'(rgb_busy), 32'd0);
    @(negedge clk);
    mon_en = 1'b1;
    @(posedge clk); #1;
    run_frame(1);
    wait_drain("midrst_drain");

    // Back-to-back frames.
    run_frame(1);
    run_frame(2);
    wait_drain("b2b_drain");

    // Random 64x64 frame with random valid and downstream busy.
    for (int r = 0; r < 64; r++)
      for (int x = 0; x < 64; x++) begin
        img[r][x]  = 24'($urandom);
        gimg[r][x] = ref_grey(img[r][x]);
      end
    for (int r = 0; r < 64; r++)
      for (int x = 0; x < 64; x++)
        big_q.push_back({(r > 0) ? gimg[r-1][x] : 8'h00, gimg[r][x],
                         (r < 63) ? gimg[r+1][x] : 8'h00});
    big_run = 1'b1;
    for (int r = 0; r < 64; r++)
      for (int x = 0; x < 64; x++) send_big(img[r][x]);
    n = 0;
    while (big_cnt < 4096 && n < 20000) begin @(negedge clk); n++; end
    big_run = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    big_obusy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("big_count", 32'(big_cnt), 32'd4096);
    chk("big_bad", 32'(big_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
